// File: rtl/flit_packetizer.sv
// rtl/flit_packetizer.sv - turns packet requests into head/body/tail flits for a ring router
//
// Purpose: accepts a packet request (destination, length) and emits a stream of
// registered flits {type[1:0], data} to the router injection port.
// Optional feature macro: PKT_STATS_EN adds saturating packet/flit counters.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   pkt_valid      in   packet request present
//   pkt_ready      out  request accepted when pkt_valid & pkt_ready (IDLE only)
//   pkt_dest       in   destination node
//   pkt_len        in   total flits in packet (0 -> 1, clamped to MAX_PKT_LEN)
//   flit_out       out  {type, data}, zero when flit_valid is low
//   flit_valid     out  flit_out valid
//   flit_ready     in   downstream accepts flit
//   dest_err       out  one-cycle pulse after a rejected request
//   pkt_sent_cnt   out  (PKT_STATS_EN) packets completed, saturating
//   flit_sent_cnt  out  (PKT_STATS_EN) flits handed off, saturating
module flit_packetizer #(
  parameter int NUM_OF_NODES    = 8,
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int NODE_ID         = 0,
  parameter int MAX_PKT_LEN     = 8,
  localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES),
  localparam int FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH + 2,
  localparam int LEN_WIDTH        = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  logic [DEST_NODE_WIDTH-1:0]  pkt_dest,
  input  logic [LEN_WIDTH-1:0]        pkt_len,
  output logic [FLIT_TOTAL_WIDTH-1:0] flit_out,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic                        dest_err
`ifdef PKT_STATS_EN
  ,
  output logic [15:0]                 pkt_sent_cnt,
  output logic [15:0]                 flit_sent_cnt
`endif
);

  localparam int ID_WIDTH = FLIT_DATA_WIDTH - DEST_NODE_WIDTH;

  localparam logic [1:0] TAIL_FLIT = 2'b00;
  localparam logic [1:0] HEAD_FLIT = 2'b01;
  localparam logic [1:0] BODY_FLIT = 2'b10;
  localparam logic [1:0] HEADER    = 2'b11;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_PKT_LEN);
  localparam logic [31:0]          NODES_U = 32'(NUM_OF_NODES);
  localparam logic [31:0]          SELF_U  = 32'(NODE_ID);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

  state_t                      r_state, w_state_next;
  logic [FLIT_TOTAL_WIDTH-1:0] r_flit_out, w_flit_out_next;
  logic                        r_flit_valid, w_flit_valid_next;
  logic                        r_dest_err, w_dest_err_next;
  logic [DEST_NODE_WIDTH-1:0]  r_dest, w_dest_next;
  logic [LEN_WIDTH-1:0]        r_len, w_len_next;
  logic [LEN_WIDTH-1:0]        r_remain, w_remain_next;
  logic [ID_WIDTH-1:0]         r_pkt_id, w_pkt_id_next;
  logic [FLIT_DATA_WIDTH-1:0]  r_payload, w_payload_next;
  logic [FLIT_DATA_WIDTH-1:0]  w_payload_inc;
  logic [LEN_WIDTH-1:0]        w_eff_len;
  logic                        w_bad_dest;
  logic                        w_hs;

  assign w_hs          = r_flit_valid & flit_ready;
  assign w_payload_inc = r_payload + 1'b1;
  assign w_bad_dest    = (32'(pkt_dest) == SELF_U) || (32'(pkt_dest) >= NODES_U);
  assign w_eff_len     = (pkt_len == '0) ? LEN_ONE :
                         (pkt_len > LEN_MAX) ? LEN_MAX : pkt_len;

  assign pkt_ready  = (r_state == S_IDLE);
  assign flit_out   = r_flit_out;
  assign flit_valid = r_flit_valid;
  assign dest_err   = r_dest_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and next-flit: the output register is loaded with the flit
  // belonging to the state being entered, so it holds whenever no handshake.
  always_comb begin
    w_state_next      = r_state;
    w_flit_out_next   = r_flit_out;
    w_flit_valid_next = r_flit_valid;
    w_dest_err_next   = 1'b0;
    w_dest_next       = r_dest;
    w_len_next        = r_len;
    w_remain_next     = r_remain;
    w_pkt_id_next     = r_pkt_id;
    w_payload_next    = r_payload;
    case (r_state)
      S_IDLE: begin
        if (pkt_valid) begin
          if (w_bad_dest) begin
            w_dest_err_next = 1'b1;
          end else begin
            w_state_next      = S_HEAD;
            w_dest_next       = pkt_dest;
            w_len_next        = w_eff_len;
            w_remain_next     = w_eff_len;
            w_flit_valid_next = 1'b1;
            w_flit_out_next   = {(w_eff_len == LEN_ONE) ? HEADER : HEAD_FLIT, pkt_dest, r_pkt_id};
          end
        end
      end
      S_HEAD: begin
        if (w_hs) begin
          w_pkt_id_next = r_pkt_id + 1'b1;
          w_remain_next = r_remain - 1'b1;
          if (r_len == LEN_ONE) begin
            w_state_next      = S_IDLE;
            w_flit_valid_next = 1'b0;
            w_flit_out_next   = '0;
          end else if (r_len == LEN_TWO) begin
            w_state_next    = S_TAIL;
            w_flit_out_next = {TAIL_FLIT, r_payload};
          end else begin
            w_state_next    = S_BODY;
            w_flit_out_next = {BODY_FLIT, r_payload};
          end
        end
      end
      S_BODY: begin
        if (w_hs) begin
          w_payload_next = w_payload_inc;
          w_remain_next  = r_remain - 1'b1;
          // Two left before this handshake means only the tail remains after it.
          if (r_remain == LEN_TWO) begin
            w_state_next    = S_TAIL;
            w_flit_out_next = {TAIL_FLIT, w_payload_inc};
          end else begin
            w_flit_out_next = {BODY_FLIT, w_payload_inc};
          end
        end
      end
      S_TAIL: begin
        if (w_hs) begin
          w_payload_next    = w_payload_inc;
          w_state_next      = S_IDLE;
          w_flit_valid_next = 1'b0;
          w_flit_out_next   = '0;
        end
      end
      default: begin
        w_state_next      = S_IDLE;
        w_flit_valid_next = 1'b0;
        w_flit_out_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flit_out   <= '0;
      r_flit_valid <= 1'b0;
      r_dest_err   <= 1'b0;
      r_dest       <= '0;
      r_len        <= '0;
      r_remain     <= '0;
      r_pkt_id     <= '0;
      r_payload    <= '0;
    end else begin
      r_flit_out   <= w_flit_out_next;
      r_flit_valid <= w_flit_valid_next;
      r_dest_err   <= w_dest_err_next;
      r_dest       <= w_dest_next;
      r_len        <= w_len_next;
      r_remain     <= w_remain_next;
      r_pkt_id     <= w_pkt_id_next;
      r_payload    <= w_payload_next;
    end
  end

`ifdef PKT_STATS_EN
  logic [15:0] r_pkt_sent_cnt;
  logic [15:0] r_flit_sent_cnt;
  logic        w_pkt_done;

  // A packet completes on its tail, or on its only flit when it is a HEADER.
  assign w_pkt_done = w_hs && ((r_state == S_TAIL) || (r_state == S_HEAD && r_len == LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_sent_cnt  <= '0;
      r_flit_sent_cnt <= '0;
    end else begin
      if (w_pkt_done && r_pkt_sent_cnt != 16'hFFFF)
        r_pkt_sent_cnt <= r_pkt_sent_cnt + 1'b1;
      if (w_hs && r_flit_sent_cnt != 16'hFFFF)
        r_flit_sent_cnt <= r_flit_sent_cnt + 1'b1;
    end
  end

  assign pkt_sent_cnt  = r_pkt_sent_cnt;
  assign flit_sent_cnt = r_flit_sent_cnt;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// tb/tb_flit_packetizer.sv - directed self-checking bench for flit_packetizer
module tb_flit_packetizer;

  logic        clk;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_dest;
  logic [3:0]  pkt_len;
  logic [17:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        dest_err;
`ifdef PKT_STATS_EN
  logic [15:0] pkt_sent_cnt;
  logic [15:0] flit_sent_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  flit_packetizer #(.NUM_OF_NODES(5), .FLIT_DATA_WIDTH(16), .NODE_ID(0), .MAX_PKT_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .dest_err   (dest_err)
`ifdef PKT_STATS_EN
    ,
    .pkt_sent_cnt  (pkt_sent_cnt),
    .flit_sent_cnt (flit_sent_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] dest, input logic [3:0] len);
    pkt_valid = 1'b1;
    pkt_dest  = dest;
    pkt_len   = len;
    check("req_ready", 32'(pkt_ready), 32'd1);
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic expect_flit(input string tag, input logic [17:0] exp);
    check({tag, "_valid"}, 32'(flit_valid), 32'd1);
    check({tag, "_data"}, 32'(flit_out), 32'(exp));
    check({tag, "_busy"}, 32'(pkt_ready), 32'd0);
    tick();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(flit_valid), 32'd0);
    check({tag, "_data"}, 32'(flit_out), 32'd0);
    check({tag, "_ready"}, 32'(pkt_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    pkt_dest   = '0;
    pkt_len    = '0;
    flit_ready = 1'b1;
    tick();
    tick();
    expect_idle("reset");
    check("reset_derr", 32'(dest_err), 32'd0);
    reset = 1'b0;
    tick();
    check("release_ready", 32'(pkt_ready), 32'd1);

    // single-flit packet: HEADER, dest 1, id 0
    req(3'd1, 4'd1);
    expect_flit("hdr1", 18'h32000);
    expect_idle("hdr1_after");

    // four-flit packet: head id 1, bodies 0,1, tail 2
    req(3'd3, 4'd4);
    expect_flit("p4_head", 18'h16001);
    expect_flit("p4_body0", 18'h20000);
    expect_flit("p4_body1", 18'h20001);
    expect_flit("p4_tail", 18'h00002);
    expect_idle("p4_after");

    // three-flit packet with a 3-cycle stall on the body flit
    req(3'd2, 4'd3);
    expect_flit("p3_head", 18'h14002);
    check("p3_body_pre", 32'(flit_out), 32'h20003);
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(flit_valid), 32'd1);
      check("stall_data", 32'(flit_out), 32'h20003);
    end
    flit_ready = 1'b1;
    tick();
    expect_flit("p3_tail", 18'h00004);
    expect_idle("p3_after");

    // rejected destinations: self and out-of-range
    req(3'd0, 4'd2);
    check("rej0_derr", 32'(dest_err), 32'd1);
    expect_idle("rej0");
    tick();
    check("rej0_derr_end", 32'(dest_err), 32'd0);
    check("rej0_novalid", 32'(flit_valid), 32'd0);
    req(3'd5, 4'd2);
    check("rej5_derr", 32'(dest_err), 32'd1);
    expect_idle("rej5");
    tick();
    check("rej5_derr_end", 32'(dest_err), 32'd0);
    check("rej5_novalid", 32'(flit_valid), 32'd0);

    // len=0 becomes a single HEADER flit, id 3
    req(3'd4, 4'd0);
    expect_flit("len0_hdr", 18'h38003);
    expect_idle("len0_after");

    // len=15 clamps to 8 flits: head id 4, bodies 5..10, tail 11
    req(3'd1, 4'd15);
    expect_flit("len15_head", 18'h12004);
    for (int i = 0; i < 6; i++) expect_flit("len15_body", 18'h20005 + 18'(i));
    expect_flit("len15_tail", 18'h0000B);
    expect_idle("len15_after");

    // reset while the second flit of a len=4 packet is on the output
    req(3'd3, 4'd4);
    expect_flit("rst_head", 18'h16005);
    check("rst_body", 32'(flit_out), 32'h2000C);
    #1 reset = 1'b1;
    #1;
    expect_idle("rst_async");
    check("rst_derr", 32'(dest_err), 32'd0);
    #2 reset = 1'b0;
    tick();
    expect_idle("rst_released");
    tick();
    expect_idle("rst_no_tail");

    // pkt_id restarted at 0 and payload counter restarted at 0
    req(3'd3, 4'd1);
    expect_flit("post_rst_hdr", 18'h36000);
    req(3'd2, 4'd2);
    expect_flit("post_rst_head", 18'h14001);
    expect_flit("post_rst_tail", 18'h00000);
    expect_idle("post_rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_packetizer.md
FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_OF_NODES, 8, ring node count.
- FLIT_DATA_WIDTH, 16, flit payload bits.
- NODE_ID, 0, this node's index.
- MAX_PKT_LEN, 8, maximum flits per packet.
- Derived (localparams):
  - DEST_NODE_WIDTH = $clog2(NUM_OF_NODES).
  - FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH+2.
  - LEN_WIDTH = $clog2(MAX_PKT_LEN+1).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- pkt_valid, in, 1, packet request present.
- pkt_ready, out, 1, request accepted this cycle when both high.
- pkt_dest, in, DEST_NODE_WIDTH, destination node.
- pkt_len, in, LEN_WIDTH, total flits in packet.
- flit_out, out, FLIT_TOTAL_WIDTH, {type[1:0], data}.
- flit_valid, out, 1, flit_out valid.
- flit_ready, in, 1, downstream (router injection port) accepts flit.
- dest_err, out, 1, one-cycle pulse: request rejected.

Function
REQ-003 Flit type codes: HEAD_FLIT=01, BODY_FLIT=10, TAIL_FLIT=00, HEADER=11 (single-flit packet).
REQ-004 FSM states: IDLE, HEAD, BODY, TAIL; pkt_ready=1 only in IDLE.
REQ-005 Request handling in IDLE when pkt_valid=1:
- Latch pkt_dest and effective length.
- Go to HEAD next cycle.
- pkt_len=0 is treated as 1.
- pkt_len>MAX_PKT_LEN is clamped to MAX_PKT_LEN.
REQ-006 Destination rejection: pkt_dest==NODE_ID or pkt_dest>=NUM_OF_NODES.
- Request is consumed and no flits are emitted.
- dest_err=1 for the next cycle.
- State stays IDLE.
REQ-007 HEAD state, flit_valid=1:
- Data = {dest, pkt_id}; pkt_id is a (FLIT_DATA_WIDTH-DEST_NODE_WIDTH)-bit counter.
- Type = HEADER if length==1, else HEAD_FLIT.
REQ-008 HEAD exit, on handshake (flit_valid&flit_ready):
- Length 1 -> IDLE.
- Length 2 -> TAIL.
- Otherwise -> BODY.
REQ-009 BODY emits BODY_FLIT with data = payload counter.
- Remaining count decrements per handshake.
- Go to TAIL when exactly one flit remains.
REQ-010 TAIL emits TAIL_FLIT with data = payload counter; -> IDLE on handshake.
REQ-011 Payload counter: FLIT_DATA_WIDTH bits, increments on every BODY/TAIL handshake, wraps to 0.
REQ-012 pkt_id increments on every HEAD/HEADER handshake, wraps to 0.
REQ-013 Output register behaviour:
- flit_out and flit_valid are registered.
- While flit_valid=1 and flit_ready=0, flit_out holds stable.
- flit_valid never deasserts without a handshake.
REQ-014 Latency: first flit valid the cycle after request acceptance.
- With flit_ready held high, a packet of length N occupies N consecutive cycles.
- One IDLE cycle separates back-to-back packets.
REQ-015 flit_out=0 whenever flit_valid=0.
REQ-016 flit_ready is ignored when flit_valid=0.

Reset
REQ-017 Assertion: reset=1 asynchronously forces:
- State IDLE.
- flit_valid=0, flit_out=0, dest_err=0.
- pkt_id=0, payload counter=0, latched dest/length=0.
REQ-018 Reset mid-packet abandons the packet; no tail flit is emitted.
REQ-019 Release: pkt_ready=1 on the first clock edge after reset deasserts.

Configuration
REQ-020 Macro PKT_STATS_EN, defined:
- Adds output pkt_sent_cnt [15:0], incremented on each TAIL or HEADER handshake.
- Adds output flit_sent_cnt [15:0], incremented on each flit handshake.
- Both saturate at 16'hFFFF and reset to 0.
REQ-021 Without PKT_STATS_EN these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-022 Defaults, NODE_ID=0, flit_ready=1; request dest=1, len=1 -> one cycle later flit_out={11,3'd1,13'd0}, valid for 1 cycle, pkt_ready back 2 cycles after accept.
REQ-023 Request dest=3, len=4 -> four consecutive flits: HEAD {01,3'd3,pkt_id}, BODY data 0, BODY data 1, TAIL data 2.
REQ-024 Request len=3, flit_ready low for 3 cycles during the BODY flit -> flit_out stable throughout the stall; sequence completes with no duplicate or lost flit.
REQ-025 Requests dest=0 and dest=5 with NUM_OF_NODES=5:
- dest=0 -> dest_err pulse, no flit_valid.
- dest=5 -> dest_err pulse, no flit_valid.
REQ-026 Request len=0 -> single HEADER flit; len=15 -> exactly 8 flits.
REQ-027 Reset asserted during the second flit of a len=4 packet -> flit_valid=0 immediately, counters 0, next packet's head carries pkt_id=0.
